// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// It takes an oversampled tick and decides each bit by a 2-of-3 majority vote
// around the bit centre. Parity mode and stop-bit count are chosen at run time.
// It detects breaks and pushes completed words to a downstream FIFO with a
// one-clock write strobe. LSR layout:
//   [0] data avail, [1] overrun, [2] parity err, [3] no framing err,
//   [4] break, [5] busy, [7:6] zero.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic                 fifo_full,
    input  logic                 clear_flags,
    output logic                 wr_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic [7:0]           LSR
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LO     = TW'(M - 1);
    localparam logic [TW-1:0] T_MID    = TW'(M);
    localparam logic [TW-1:0] T_HI     = TW'(M + 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    // sync_q[SYNC_STAGES-1] is the synchronised line, sync_q[SYNC_STAGES] its previous value.
    logic [SYNC_STAGES:0] sync_q;
    // primed_q fills with ones as real line samples reach each stage, so the
    // reset value of the synchroniser never looks like a falling edge.
    logic [SYNC_STAGES:0] primed_q;

    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic                 stop_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 pend_q;
    logic                 use_par_q;
    logic                 odd_q;
    logic                 two_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 pbit_q;

    logic                 avail_q;
    logic                 ovr_q;
    logic                 perr_lsr_q;
    logic                 nferr_q;
    logic                 brk_q;
    logic                 busy_q;

    logic rx_s;
    logic fall;
    logic maj;
    logic ferr_now;
    logic brk_now;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = primed_q[SYNC_STAGES] & sync_q[SYNC_STAGES] & ~rx_s;
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    // Only meaningful on the final stop-bit vote: includes that bit's own vote.
    assign ferr_now = ferr_q | ~maj;
    assign brk_now  = (word_q == '0) && !pbit_q && ferr_now;

    assign LSR = {2'b00, busy_q, brk_q, nferr_q, perr_lsr_q, ovr_q, avail_q};

    // Bring the asynchronous line into the clock domain and track priming.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= '1;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-1:0], rx};
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame FSM, majority sampling, completion handling and LSR flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            samp_q     <= '0;
            word_q     <= '0;
            pend_q     <= 1'b0;
            use_par_q  <= 1'b0;
            odd_q      <= 1'b0;
            two_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            wr_en      <= 1'b0;
            data_out   <= '0;
            avail_q    <= 1'b0;
            ovr_q      <= 1'b0;
            perr_lsr_q <= 1'b0;
            nferr_q    <= 1'b1;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            // Sets below are written later, so they override a same-cycle clear.
            if (clear_flags) begin
                avail_q <= 1'b0;
                ovr_q   <= 1'b0;
                brk_q   <= 1'b0;
            end

            if (b_tick && state_q != IDLE) begin
                if (tick_q == T_LO)  samp_q[0] <= rx_s;
                if (tick_q == T_MID) samp_q[1] <= rx_s;
                tick_q <= (tick_q == T_END) ? '0 : tick_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    // An edge between ticks is held until the next tick.
                    if (b_tick && (fall || pend_q) && !rx_s) begin
                        state_q   <= START;
                        busy_q    <= 1'b1;
                        tick_q    <= '0;
                        pend_q    <= 1'b0;
                        use_par_q <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        odd_q     <= (parity_mode == 2'b10);
                        two_q     <= stop_bits;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        pbit_q    <= 1'b0;
                    end else if (fall) begin
                        pend_q <= 1'b1;
                    end else if (rx_s) begin
                        pend_q <= 1'b0;
                    end
                end

                START: begin
                    if (b_tick) begin
                        if (tick_q == T_HI && maj) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (tick_q == T_END) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end
                end

                DATA: begin
                    if (b_tick) begin
                        if (tick_q == T_HI) begin
                            word_q <= {maj, word_q[DATA_BITS-1:1]};
                        end else if (tick_q == T_END) begin
                            if (bit_q == LAST_BIT) begin
                                state_q <= use_par_q ? PARITY : STOP;
                                stop_q  <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end

                PARITY: begin
                    if (b_tick) begin
                        if (tick_q == T_HI) begin
                            pbit_q <= maj;
                            perr_q <= maj ^ (odd_q ? ~(^word_q) : ^word_q);
                        end else if (tick_q == T_END) begin
                            state_q <= STOP;
                            stop_q  <= 1'b0;
                        end
                    end
                end

                STOP: begin
                    if (b_tick) begin
                        if (tick_q == T_HI) begin
                            if (stop_q == two_q) begin
                                // Complete mid stop bit so the next start edge is never missed.
                                if (brk_now) begin
                                    brk_q   <= 1'b1;
                                    state_q <= WAIT_IDLE;
                                end else begin
                                    if (fifo_full) begin
                                        ovr_q <= 1'b1;
                                    end else begin
                                        wr_en      <= 1'b1;
                                        data_out   <= word_q;
                                        perr_lsr_q <= perr_q;
                                        nferr_q    <= ~ferr_now;
                                        avail_q    <= 1'b1;
                                    end
                                    state_q <= ferr_now ? WAIT_IDLE : IDLE;
                                    busy_q  <= ferr_now;
                                end
                            end else begin
                                ferr_q <= ferr_now;
                            end
                        end else if (tick_q == T_END) begin
                            stop_q <= 1'b1;
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8-bit default build plus a 5-bit build.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int OS     = 16;
    localparam int DIV    = 2;
    localparam int BITCLK = OS * DIV;

    typedef struct {
        logic [7:0] d;
        logic [7:0] lsr;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] pm;
        logic       sb;
        logic       flip;
        logic       stoplow;
        logic       full;
        logic       clr_after;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       b_tick = 1'b0;
    logic       rx8, rx5;
    logic [1:0] pm;
    logic       sb, full, clr;
    logic [1:0] pm5;
    logic       sb5, full5, clr5;
    logic       wr8, wr5;
    logic [7:0] dout8, lsr8, lsr5;
    logic [4:0] dout5;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr5 = 0;

    logic m_avail, m_ovr, m_brk, m_perr, m_nferr;
    logic [7:0] m_data;

    vec_t vt[8];

    always #5 clock = ~clock;

    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            b_tick = ((n % DIV) == 0);
        end
    end

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut8 (
        .clock(clock), .reset(reset), .b_tick(b_tick), .rx(rx8),
        .parity_mode(pm), .stop_bits(sb), .fifo_full(full), .clear_flags(clr),
        .wr_en(wr8), .data_out(dout8), .LSR(lsr8)
    );

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut5 (
        .clock(clock), .reset(reset), .b_tick(b_tick), .rx(rx5),
        .parity_mode(pm5), .stop_bits(sb5), .fifo_full(full5), .clear_flags(clr5),
        .wr_en(wr5), .data_out(dout5), .LSR(lsr5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_lsr(input logic busy);
        return {2'b00, busy, m_brk, m_nferr, m_perr, m_ovr, m_avail};
    endfunction

    // Scoreboard: every write strobe pops one expected word.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (wr8 === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected wr_en", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("data_out at wr_en", dout8, e.d);
                check("LSR at wr_en", lsr8, e.lsr);
            end
        end
        if (wr5 === 1'b1) n_wr5++;
    end

    task automatic drive_bit(input logic sel5, input logic v);
        if (sel5) rx5 = v;
        else rx8 = v;
        repeat (BITCLK) @(negedge clock);
    endtask

    task automatic send_frame(input logic sel5, input int nbits, input logic [8:0] d,
                              input logic [1:0] mode, input logic two,
                              input logic flip, input logic stoplow);
        logic p;
        pm = mode;
        sb = two;
        drive_bit(sel5, 1'b0);
        // Config changes after the start bit must not affect this frame.
        pm = ~mode;
        sb = ~two;
        for (int i = 0; i < nbits; i++) drive_bit(sel5, d[i]);
        if (mode == 2'b01 || mode == 2'b10) begin
            p = 1'b0;
            for (int i = 0; i < nbits; i++) p = p ^ d[i];
            if (mode == 2'b10) p = ~p;
            drive_bit(sel5, p ^ flip);
        end
        drive_bit(sel5, ~stoplow);
        if (two) drive_bit(sel5, 1'b1);
        drive_bit(sel5, 1'b1);
        drive_bit(sel5, 1'b1);
        pm = mode;
        sb = two;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        m_avail = 1'b0;
        m_ovr   = 1'b0;
        m_brk   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic use_par, p, perr, brk;
        exp_t e;
        use_par = (v.pm == 2'b01) || (v.pm == 2'b10);
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ v.d[i];
        if (v.pm == 2'b10) p = ~p;
        p = p ^ v.flip;
        perr = use_par && v.flip;
        brk  = (v.d == 8'h00) && (!use_par || !p) && v.stoplow;
        if (brk) begin
            m_brk = 1'b1;
        end else if (v.full) begin
            m_ovr = 1'b1;
        end else begin
            m_data  = v.d;
            m_perr  = perr;
            m_nferr = ~v.stoplow;
            m_avail = 1'b1;
            e.d   = v.d;
            e.lsr = model_lsr(v.stoplow);
            sbq.push_back(e);
        end
        full = v.full;
        send_frame(1'b0, 8, {1'b0, v.d}, v.pm, v.sb, v.flip, v.stoplow);
        full = 1'b0;
        check("frame pushed", sbq.size(), 0);
        check("LSR after frame", lsr8, model_lsr(1'b0));
        check("data_out after frame", dout8, m_data);
        if (v.clr_after) begin
            pulse_clear();
            check("LSR after clear", lsr8, model_lsr(1'b0));
        end
    endtask

    task automatic model_reset();
        m_avail = 1'b0;
        m_ovr   = 1'b0;
        m_brk   = 1'b0;
        m_perr  = 1'b0;
        m_nferr = 1'b1;
        m_data  = 8'h00;
    endtask

    initial begin
        //        d      pm     sb    flip  stlow full  clr
        vt[0] = '{8'hA5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8'h81, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        rx8 = 1'b1; rx5 = 1'b1;
        pm = 2'b00; sb = 1'b0; full = 1'b0; clr = 1'b0;
        pm5 = 2'b00; sb5 = 1'b0; full5 = 1'b0; clr5 = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset LSR", lsr8, 8'h08);
        check("reset data_out", dout8, 8'h00);
        check("reset wr_en", wr8, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Start-bit glitch: low for 4 ticks only.
        rx8 = 1'b0;
        repeat (4 * DIV) @(negedge clock);
        rx8 = 1'b1;
        check("busy during start", lsr8[5], 1'b1);
        repeat (BITCLK) @(negedge clock);
        check("LSR after glitch", lsr8, 8'h08);
        run_vec('{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Break: line low for 12 bit times.
        pm = 2'b00; sb = 1'b0;
        rx8 = 1'b0;
        repeat (12 * BITCLK) @(negedge clock);
        m_brk = 1'b1;
        check("LSR during break", lsr8, model_lsr(1'b1));
        rx8 = 1'b1;
        repeat (4) @(negedge clock);
        check("LSR after break release", lsr8, model_lsr(1'b0));
        pulse_clear();
        check("LSR after break clear", lsr8, model_lsr(1'b0));
        repeat (BITCLK) @(negedge clock);

        // Reset in the middle of data bit 4 of 0xF0.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        rx8 = 1'b1;
        repeat (BITCLK / 2) @(negedge clock);
        check("busy before reset", lsr8[5], 1'b1);
        reset = 1'b0;
        #1;
        check("mid-frame reset LSR", lsr8, 8'h08);
        check("mid-frame reset data_out", dout8, 8'h00);
        check("mid-frame reset wr_en", wr8, 1'b0);
        model_reset();
        // Line held low while coming out of reset must not start a frame.
        rx8 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (12 * BITCLK) @(negedge clock);
        check("LSR with line low from reset", lsr8, 8'h08);
        rx8 = 1'b1;
        repeat (2 * BITCLK) @(negedge clock);
        run_vec(vt[7]);

        // 5-bit build, no parity, one stop bit.
        send_frame(1'b1, 5, 9'h015, 2'b00, 1'b0, 1'b0, 1'b0);
        check("5-bit wr_en pulses", n_wr5, 1);
        check("5-bit data_out", dout5, 5'h15);
        check("5-bit LSR", lsr5, 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed-format UART receiver. It has a configurable data width and oversampling ratio, plus run-time selectable parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and the block adds break detection, a busy flag and a push-style FIFO write strobe. It sits between baud_tick_gen (oversampled tick) and the RX fifo, and exports an extended LSR for packing alongside the data word.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first on the line
OVERSAMPLE, 16, b_tick pulses per bit period, even, minimum 8
SYNC_STAGES, 2, rx synchroniser depth, minimum 2

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous active-low reset
b_tick  input  1  one-clock pulse at OVERSAMPLE x baud
rx  input  1  serial line, idle high, asynchronous to clock
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
fifo_full  input  1  downstream FIFO full
clear_flags  input  1  clears sticky LSR bits
wr_en  output  1  one-clock write strobe to FIFO
data_out  output  DATA_BITS  last received word
LSR  output  8  [0] data avail, [1] overrun, [2] parity err, [3] no framing err, [4] break, [5] busy, [7:6] 0

Behaviour:
- Reset (reset=0, async): state IDLE, synchroniser flops = 1, counters = 0, wr_en = 0, data_out = 0, LSR = 8'h08.
- rx passes through SYNC_STAGES flops. A falling edge is rx_s=0 with previous rx_s=1. A line held low out of reset never starts a frame.
- Let M = OVERSAMPLE/2. Within each bit period the tick counter runs 0..OVERSAMPLE-1 and advances only on b_tick. rx_s is sampled on ticks M-1, M and M+1; the bit value is the 2-of-3 majority.
- parity_mode and stop_bits are latched when the falling edge is accepted. Changes mid-frame have no effect until the next frame.
- State IDLE: on a falling edge coinciding with b_tick -> START, tick counter = 0.
- State START: at tick M+1, majority=1 is a glitch -> IDLE with no flag change. Otherwise continue to tick OVERSAMPLE-1 -> DATA.
- State DATA: shift DATA_BITS majority values LSB first. After the last bit -> PARITY if the latched mode is even/odd, else STOP.
- State PARITY: expected bit is ^data for even and ~^data for odd. A mismatch sets per-frame perr.
- State STOP: one or two stop periods. Any stop majority of 0 sets per-frame ferr. The frame completes at tick M+1 of the last stop bit, not at the period end, so back-to-back frames resync.
- Completion, normal frame:
  - If fifo_full=0: data_out <= word, LSR[2] <= perr, LSR[3] <= ~ferr, LSR[0] <= 1, and wr_en is high for exactly one clock in the same cycle that data_out updates.
  - If fifo_full=1: no wr_en, data_out and LSR[2:3] unchanged, LSR[1] <= 1.
- Completion, break (word = 0, parity bit 0 or absent, ferr = 1): no wr_en, LSR[4] <= 1 -> WAIT_IDLE.
- Completion with ferr but not break -> word still pushed per the rule above, then WAIT_IDLE.
- State WAIT_IDLE: stay until rx_s=1, then -> IDLE.
- Sticky bits LSR[0], LSR[1] and LSR[4] clear on clear_flags. If set and clear occur in the same cycle, set wins. LSR[2:3] are per-frame and are not cleared by clear_flags.
- LSR[5] = (state != IDLE), registered.
- Latency: wr_en asserts (SYNC_STAGES) clocks plus the tick at M+1 of the last stop bit after the line event.
- Reset asserted mid-frame discards the partial frame immediately. After release, the next valid frame is received normally.

Test Plan:
- Defaults, even parity, two stop bits, send 8'hA5 -> single wr_en pulse, data_out=8'hA5, LSR=8'h09; clear_flags -> LSR=8'h08.
- Odd parity, send 8'h3C with parity bit inverted -> wr_en pulse, data_out=8'h3C, LSR[2]=1, LSR[3]=1.
- Start glitch: rx low for 4 b_ticks then high -> no wr_en, state back to IDLE, LSR unchanged. A following clean 8'h5A is received correctly.
- fifo_full=1 across completion of 8'h5A -> no wr_en, LSR[1]=1, data_out keeps the previous value. Drop fifo_full, send 8'h11 -> pushed, LSR[1] still 1 until clear_flags.
- rx held low 12 bit times then released -> LSR[4]=1, no wr_en, LSR[5]=1 until rx returns high. Stop-bit-low on 8'hC3 -> pushed with LSR[3]=0.
- Reset pulsed low during data bit 4 -> outputs at reset values immediately. Next frame 8'h81 is received correctly. DATA_BITS=5 build, parity none, one stop bit, send 5'h15 -> data_out=5'h15.
